anacore_tap_sequencer: RTL
==========================

Name: anacore_tap_sequencer

Overview:
- Digital controller for the next-generation parametrised analog pad cell.
- Connects the pad to exactly one of NTAP core taps (ESD/resistor taps), or to none, through per-tap switch enables.
- Switching is break-before-make, with a programmable dead time and a programmable settle time.
- Sits in the always-on core domain beside the pad ring; consumes select requests from the pad configuration block over a valid/ready handshake.

Parameters:
- NTAP, 8: number of analog taps; legal range 2..32.
- CNT_W, 8: width of the dead-time and settle-time counters.
- IDX_W, $clog2(NTAP+1): width of the tap index. Index value NTAP means "all open".

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_valid  in  1  select request valid.
- sel_ready  out  1  controller can accept a request.
- sel_idx  in  IDX_W  requested tap; value NTAP = open all.
- dead_cycles  in  CNT_W  break duration in clocks; sampled at accept.
- settle_cycles  in  CNT_W  settle duration in clocks; sampled at accept.
- sw_en  out  NTAP  tap switch enables; one-hot or all zero.
- cur_idx  out  IDX_W  currently connected tap; NTAP when open.
- busy  out  1  switching in progress.
- settled  out  1  connection stable.
- err  out  1  one-cycle pulse on an illegal index (sel_idx > NTAP).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - sw_en=0, cur_idx=NTAP, busy=0, settled=0, err=0.
  - State OPEN, sel_ready=1.
- States and transitions:
  - OPEN: sel_ready=1, settled=0.
    - Accept (valid&ready) with idx<NTAP -> BREAK.
    - Accept with idx==NTAP -> stay OPEN, no other effect.
    - Accept with idx>NTAP -> err=1 next cycle, stay OPEN.
  - BREAK: sw_en=0, cur_idx=NTAP, busy=1, sel_ready=0.
    - Counts max(dead_cycles,1) clocks, so at least one all-open cycle always occurs.
    - Then: target<NTAP -> MAKE; target==NTAP -> OPEN.
  - MAKE: sw_en=one-hot(target), cur_idx=target, busy=1, sel_ready=0.
    - Counts settle_cycles clocks; 0 means settled in the following cycle.
    - Then -> STABLE.
  - STABLE: settled=1, busy=0, sel_ready=1.
    - Accept idx==cur_idx: no switching; settled stays 1 with no glitch.
    - Accept any other legal idx (including NTAP) -> BREAK.
    - Accept idx>NTAP: err pulse, connection unchanged, stay STABLE.
- Timing:
  - All outputs are registered.
  - sw_en changes exactly one cycle after the accept edge.
  - Two different bits of sw_en are never set together in any cycle.
  - A tap enable is never asserted without a preceding all-zero cycle on sw_en.
- Handshake:
  - Accept = sel_valid & sel_ready at the clock edge.
  - sel_idx, dead_cycles and settle_cycles are sampled only at accept.
  - sel_valid while sel_ready=0 is ignored. The source must hold it; the controller never queues.
- Counters:
  - CNT_W bits wide, count down from the sampled value, no wrap.
  - dead_cycles = 2^CNT_W-1 gives exactly that many BREAK cycles.
- Reset mid-operation: any state returns to OPEN and sw_en clears immediately (asynchronously).
- cur_idx is written only when sw_en changes.

Test Plan:
- Reset, then request idx=3, dead=2, settle=4.
  - sel_ready drops the next cycle.
  - sw_en=0 for 2 cycles, then 8'b0000_1000 for 4 cycles with busy=1.
  - Then settled=1, sel_ready=1, cur_idx=3.
- From STABLE on tap 3, request idx=5, dead=0, settle=0.
  - Exactly 1 cycle sw_en=0, then 8'b0010_0000.
  - settled=1 the following cycle.
  - An assertion confirms sw_en is never non-one-hot across the whole run.
- From STABLE on tap 5, request idx=5.
  - sw_en, cur_idx and settled are unchanged in every cycle; busy stays 0.
- From STABLE on tap 5, request idx=9 (NTAP=8).
  - err=1 for exactly one cycle; tap 5 stays connected.
- From STABLE, request idx=8 with dead=3.
  - 3 cycles BREAK, then OPEN with sw_en=0, cur_idx=8, settled=0.
- Assert rst_n=0 mid-MAKE (settle=200, cycle 50).
  - sw_en=0 asynchronously, before the next clock edge.
  - After release: OPEN, sel_ready=1, all outputs at their reset values.

Source files
------------

// File: rtl/anacore_tap_sequencer.sv
// rtl/anacore_tap_sequencer.sv - break-before-make analog tap selector with dead and settle timing
// Connects the pad to at most one of NTAP taps; every output comes straight from a flop.
module anacore_tap_sequencer #(
  parameter int NTAP  = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(NTAP + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  input  logic [IDX_W-1:0] sel_idx_i,
  input  logic [CNT_W-1:0] dead_cycles_i,
  input  logic [CNT_W-1:0] settle_cycles_i,
  output logic [NTAP-1:0]  sw_en_o,
  output logic [IDX_W-1:0] cur_idx_o,
  output logic             busy_o,
  output logic             settled_o,
  output logic             err_o
);

  localparam logic [IDX_W-1:0] OPEN_IDX = IDX_W'(NTAP);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [NTAP-1:0]  BIT0     = NTAP'(1);

  typedef enum logic [1:0] {S_OPEN, S_BREAK, S_MAKE, S_STABLE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic [NTAP-1:0]  sw_en_q, sw_en_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             busy_q, busy_d;
  logic             settled_q, settled_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             accept, illegal, connected;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    tgt_d    = tgt_q;
    err_d    = 1'b0;
    accept   = sel_valid_i & ready_q;
    illegal  = sel_idx_i > OPEN_IDX;

    case (state_q)
      S_OPEN, S_STABLE: begin
        // In OPEN cur_idx is NTAP, so an "open all" request there is a no-op.
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (sel_idx_i != cur_idx_q) begin
            state_d  = S_BREAK;
            tgt_d    = sel_idx_i;
            settle_d = settle_cycles_i;
            cnt_d    = (dead_cycles_i == '0) ? ONE : dead_cycles_i;
          end
        end
      end
      S_BREAK: begin
        if (cnt_q == ONE) begin
          if (tgt_q == OPEN_IDX) begin
            state_d = S_OPEN;
          end else begin
            state_d = S_MAKE;
            cnt_d   = (settle_q == '0) ? ONE : settle_q;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_MAKE: begin
        if (cnt_q == ONE) state_d = S_STABLE;
        else              cnt_d   = cnt_q - ONE;
      end
      default: state_d = S_OPEN;
    endcase

    connected = (state_d == S_MAKE) || (state_d == S_STABLE);
    sw_en_d   = connected ? (BIT0 << tgt_d) : '0;
    cur_idx_d = connected ? tgt_d : OPEN_IDX;
    busy_d    = (state_d == S_BREAK) || (state_d == S_MAKE);
    settled_d = (state_d == S_STABLE);
    ready_d   = ~busy_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OPEN;
      cnt_q     <= '0;
      settle_q  <= '0;
      tgt_q     <= OPEN_IDX;
      sw_en_q   <= '0;
      cur_idx_q <= OPEN_IDX;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      tgt_q     <= tgt_d;
      sw_en_q   <= sw_en_d;
      cur_idx_q <= cur_idx_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign sw_en_o     = sw_en_q;
  assign cur_idx_o   = cur_idx_q;
  assign busy_o      = busy_q;
  assign settled_o   = settled_q;
  assign sel_ready_o = ready_q;
  assign err_o       = err_q;

endmodule
